button_debounce: RTL
====================

Name: button_debounce

Overview:
Input-side counterpart to the LED output path in the blink designs. It conditions a raw, asynchronous, bouncing board input, such as a push-button, into a clean level in the `clk` domain, plus single-cycle edge pulses and a press counter. It sits between a top-level input pin and user logic, for example the blink toggle or the processor's GPIO sampling.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the metastability synchronizer on `inSignal`; legal range 2..4.
- DEBOUNCE_CYCLES, 120000: consecutive cycles the synchronized input must hold a new level before it is accepted (10 ms at 12 MHz); must be >= 2.
- CNT_WIDTH, 17: width of the debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- COUNT_WIDTH, 8: width of `pressCount`.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `inSignal`, input, 1: raw asynchronous pin level; 1 = pressed.
- `stableLevel`, output, 1: debounced level, registered.
- `risePulse`, output, 1: one-cycle pulse when `stableLevel` goes 0->1.
- `fallPulse`, output, 1: one-cycle pulse when `stableLevel` goes 1->0.
- `pressCount`, output, COUNT_WIDTH: number of accepted presses (rising edges), modulo 2^COUNT_WIDTH.
- `longPress`, output, 1: see Optional Feature; constant 0 when the feature is compiled out.

Behaviour:
- **Reset (asynchronous, any time):**
  - All synchronizer flops = 0; `stableLevel` = 0; `risePulse` = 0; `fallPulse` = 0; `pressCount` = 0; `longPress` = 0.
  - Debounce counter = 0; FSM = STABLE_LOW.
  - A reset mid-debounce discards the partial count.
- **Synchronizer:**
  - `inSignal` passes through a SYNC_STAGES-deep flop chain; call the last stage `syncIn`.
  - No other logic reads `inSignal` directly.
- **FSM states:** STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
- **STABLE_LOW:**
  - `syncIn` = 1 -> CHECK_HIGH, counter = 1.
  - Otherwise stay, counter = 0.
- **CHECK_HIGH:**
  - `syncIn` = 0 -> STABLE_LOW, counter = 0 (bounce rejected, no output change).
  - `syncIn` = 1 and counter == DEBOUNCE_CYCLES-1 -> STABLE_HIGH, counter = 0, `stableLevel` <= 1, `risePulse` <= 1, `pressCount` <= `pressCount`+1.
  - Otherwise counter += 1.
- **STABLE_HIGH and CHECK_LOW:** mirror STABLE_LOW and CHECK_HIGH with polarity inverted. Acceptance sets `stableLevel` <= 0 and `fallPulse` <= 1; `pressCount` is unchanged.
- **Pulses:**
  - `risePulse` and `fallPulse` are high for exactly one cycle, the cycle in which `stableLevel` first shows the new value.
  - The two pulses are never high together.
- **Latency:** a clean input step reaches `stableLevel` SYNC_STAGES + DEBOUNCE_CYCLES clock edges after the first edge that samples it.
- **Glitch rejection:** any excursion shorter than DEBOUNCE_CYCLES cycles at `syncIn` produces no change on any output.
- **Counter width:** the counter never exceeds DEBOUNCE_CYCLES-1.
- **`pressCount` wrap:** 2^COUNT_WIDTH-1 -> 0 on the next accepted press, with no flag.
- **Holding:** holding the input indefinitely produces no further pulses.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_LONG_PRESS_EN, which adds parameter LONG_PRESS_CYCLES (default 12000000, 1 s at 12 MHz).
- **Defined:**
  - A hold counter runs while FSM = STABLE_HIGH, starting at 0 on entry.
  - When it reaches LONG_PRESS_CYCLES-1, `longPress` pulses high for exactly one cycle and the counter saturates; no repeat until the next press.
  - Leaving STABLE_HIGH or reset clears the counter.
- **Undefined:** the hold counter is not instantiated; `longPress` is tied to 0.

Test Plan (sim params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, COUNT_WIDTH=3, LONG_PRESS_CYCLES=10):
- Reset, then drive `inSignal` 0->1 and hold. Required: `stableLevel` goes 1 exactly 6 edges later; `risePulse` high for 1 cycle on that same cycle; `pressCount` = 1; `fallPulse` stays 0.
- From STABLE_LOW, pulse `inSignal` high for 3 cycles, then low. Required: no output changes. Then the bounce pattern 1,0,1,1,0,1,1,1,1 (one value per cycle). Required: exactly one `risePulse`, after the final four 1s have reached `syncIn`.
- From STABLE_HIGH, drive 1->0 and hold. Required: `fallPulse` for 1 cycle 6 edges later; `stableLevel` = 0; `pressCount` unchanged.
- Perform 8 clean presses. Required: `pressCount` sequence 1..7 then 0.
- Assert `reset` asynchronously (not clock-aligned) mid-CHECK_HIGH with counter = 2. Required: all outputs 0 immediately. After release with input held at 1, the full 6-edge latency restarts.
- With BUTTON_DEBOUNCE_LONG_PRESS_EN defined, hold pressed. Required: `longPress` one-cycle pulse 10 cycles after `risePulse`, and never again while held. With the macro undefined, `longPress` stays 0 throughout.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces a raw board input into a clean
// clk-domain level, with one-cycle rise/fall pulses and a press counter.
// Optional long-press detector: define BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_WIDTH       = 17,
  parameter int unsigned COUNT_WIDTH     = 8
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inSignal,
  output logic                   stableLevel,
  output logic                   risePulse,
  output logic                   fallPulse,
  output logic [COUNT_WIDTH-1:0] pressCount,
  output logic                   longPress
);

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_CHECK_HIGH  = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_CHECK_LOW   = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [COUNT_WIDTH-1:0] press_q, press_d;
  logic                   accept_rise_c;
  logic                   accept_fall_c;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Metastability synchronizer; the only consumer of the raw pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inSignal};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STABLE_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and debounce-counter logic; counter restarts on any bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_STABLE_LOW: begin
        if (sync_in) begin
          state_d = ST_CHECK_HIGH;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      ST_CHECK_HIGH: begin
        if (!sync_in) begin
          state_d = ST_STABLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_STABLE_HIGH: begin
        if (!sync_in) begin
          state_d = ST_CHECK_LOW;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      ST_CHECK_LOW: begin
        if (sync_in) begin
          state_d = ST_STABLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_STABLE_LOW;
      end
    endcase
  end

  // Output next-values: level, edge pulses and press count change only on acceptance.
  always_comb begin
    accept_rise_c = (state_q == ST_CHECK_HIGH) && sync_in && (cnt_q == CNT_LAST);
    accept_fall_c = (state_q == ST_CHECK_LOW) && !sync_in && (cnt_q == CNT_LAST);
    stable_d      = stable_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    press_d       = press_q;
    if (accept_rise_c) begin
      stable_d = 1'b1;
      rise_d   = 1'b1;
      press_d  = press_q + COUNT_WIDTH'(1);
    end else if (accept_fall_c) begin
      stable_d = 1'b0;
      fall_d   = 1'b1;
    end
  end

  // Counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      press_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      press_q  <= press_d;
    end
  end

  assign stableLevel = stable_q;
  assign risePulse   = rise_q;
  assign fallPulse   = fall_q;
  assign pressCount  = press_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              fired_q, fired_d;
  logic              long_q, long_d;

  // Hold timer: counts while stably high, saturates, fires once per accepted press.
  always_comb begin
    hold_d  = '0;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (state_q == ST_STABLE_HIGH) begin
      if (hold_q == HOLD_LAST) begin
        hold_d = hold_q;
        if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end else if ((state_q == ST_STABLE_LOW) || (state_q == ST_CHECK_HIGH)) begin
      fired_d = 1'b0;
    end
  end

  // Hold timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign longPress = long_q;
`else
  assign longPress = 1'b0;
`endif

endmodule
